// File: rtl/max7219_receiver_pkg.sv
// rtl/max7219_receiver_pkg.sv - shared constants for the MAX7219 receiver
package max7219_receiver_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCAN      = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // Segments A..G (bit6..bit0) for Code-B symbols 0-9, '-', E, H, L, P, blank
  localparam logic [6:0] CODE_B_SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00
  };

endpackage

// File: rtl/max7219_code_b_decode.sv
// rtl/max7219_code_b_decode.sv - Code-B symbol to segment decoder (combinational)
module max7219_code_b_decode
  import max7219_receiver_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {i_dp, CODE_B_SEG[i_code]};

endmodule

// File: rtl/max7219_receiver.sv
// rtl/max7219_receiver.sv - MAX7219-compatible serial receiver with registered segment outputs
module max7219_receiver
  import max7219_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_serial_clk,
  input  logic        i_serial_din,
  input  logic        i_serial_load,
  output logic        o_serial_dout,
  output logic [63:0] o_seg,
  output logic [3:0]  o_intensity,
  output logic        o_frame_stb,
  output logic        o_frame_err
);

  // Each synchronizer stage carries {load, din, clk}
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [1:0]                  prev_q, prev_d;
  logic                        s_clk, s_din, s_load;
  logic                        clk_rise, clk_fall, load_rise;

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dout_q, dout_d;
  logic                  pend_q, pend_d;
  logic                  err_q, err_d;
  logic [11:0]           frame_q, frame_d;

  logic [7:0][7:0] digit_q, digit_d;
  logic [7:0]      decode_q, decode_d;
  logic [3:0]      intensity_q, intensity_d;
  logic [2:0]      scan_q, scan_d;
  logic            run_q, run_d;
  logic            test_q, test_d;
  logic [7:0][7:0] seg_q, seg_d;
  logic [7:0][7:0] dec_seg;
  logic [2:0]      dig_idx;

  assign s_clk     = sync_q[SYNC_STAGES-1][0];
  assign s_din     = sync_q[SYNC_STAGES-1][1];
  assign s_load    = sync_q[SYNC_STAGES-1][2];
  assign clk_rise  = s_clk & ~prev_q[0];
  assign clk_fall  = ~s_clk & prev_q[0];
  assign load_rise = s_load & ~prev_q[1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {i_serial_load, i_serial_din, i_serial_clk}};
    prev_d = {s_load, s_clk};
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    frame_d = frame_q;
    pend_d  = 1'b0;
    err_d   = 1'b0;
    if (clk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], s_din};
      if (cnt_q != CNT_W'(FRAME_BITS)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (clk_fall) begin
      dout_d = shift_q[FRAME_BITS-1];
    end
    // LOAD looks at the post-shift view so a coincident CLK rise joins the frame
    if (load_rise) begin
      if (cnt_d == CNT_W'(FRAME_BITS)) begin
        pend_d  = 1'b1;
        frame_d = shift_d[11:0];
      end else begin
        err_d = 1'b1;
      end
      cnt_d = '0;
    end
  end

  assign dig_idx = 3'(frame_q[11:8] - ADDR_DIGIT0);

  always_comb begin
    digit_d     = digit_q;
    decode_d    = decode_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    run_d       = run_q;
    test_d      = test_q;
    if (pend_q) begin
      case (frame_q[11:8])
        ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
        ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                        digit_d[dig_idx] = frame_q[7:0];
        ADDR_DECODE:    decode_d         = frame_q[7:0];
        ADDR_INTENSITY: intensity_d      = frame_q[3:0];
        ADDR_SCAN:      scan_d           = frame_q[2:0];
        ADDR_SHUTDOWN:  run_d            = frame_q[0];
        ADDR_TEST:      test_d           = frame_q[0];
        default:        ;
      endcase
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_decode
    max7219_code_b_decode u_code_b (
      .i_code (digit_q[g][3:0]),
      .i_dp   (digit_q[g][7]),
      .o_seg  (dec_seg[g])
    );
  end

  always_comb begin
    seg_d = '0;
    for (int n = 0; n < 8; n++) begin
      if (test_q) begin
        seg_d[n] = 8'hFF;
      end else if (!run_q || (3'(n) > scan_q)) begin
        seg_d[n] = 8'h00;
      end else if (decode_q[n]) begin
        seg_d[n] = dec_seg[n];
      end else begin
        seg_d[n] = digit_q[n];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q      <= '0;
      prev_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      dout_q      <= 1'b0;
      frame_q     <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      digit_q     <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      run_q       <= 1'b0;
      test_q      <= 1'b0;
      seg_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      frame_q     <= frame_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      digit_q     <= digit_d;
      decode_q    <= decode_d;
      intensity_q <= intensity_d;
      scan_q      <= scan_d;
      run_q       <= run_d;
      test_q      <= test_d;
      seg_q       <= seg_d;
    end
  end

  assign o_serial_dout = dout_q;
  assign o_seg         = seg_q;
  assign o_intensity   = intensity_q;
  assign o_frame_stb   = pend_q;
  assign o_frame_err   = err_q;

endmodule
